// File: rtl/alu_slice_unit.sv
// alu_slice_unit
//   Registered WIDTH-bit ripple-carry ALU for the execute stage. The datapath
//   is a chain of 1-bit slices. It also holds a zero detector and a separate
//   4-to-16 one-hot decoder. Every output is registered, so there is one
//   cycle of latency and a new operation can be accepted on every clock.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset; clears all registered state
//   in_valid   operands and opcode are valid this cycle
//   A, B       WIDTH-bit operands
//   cntrl      opcode
//                000 = B,   010 = A+B,   011 = A-B,
//                100 = A&B, 101 = A|B,   110 = A^B,
//                001 and 111 = 0
//   dec_sel    decoder select
//   dec_en     decoder enable
//   out_valid  registered in_valid
//   result     registered ALU result
//   negative   registered N flag
//   zero       registered Z flag
//   overflow   registered V flag
//   carry_out  registered C flag (for subtract: 1 = no borrow)
//   dec_out    registered one-hot decode of dec_sel, gated by dec_en
module alu_slice_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic [3:0]       dec_sel,
  input  logic             dec_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic [15:0]      dec_out
);

  localparam int NIB = WIDTH / 4;

  // One-hot 4-to-16 decode; the output is all zero when en is low.
  function automatic logic [15:0] dec16(input logic [3:0] sel, input logic en);
    logic [15:0] o;
    o = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      o[k] = en & (sel == 4'(k));
    end
    return o;
  endfunction

  // Per-slice result mux.
  function automatic logic slice_mux(input logic [2:0] op, input logic a,
                                     input logic b, input logic s);
    logic r;
    case (op)
      3'b000:         r = b;
      3'b010, 3'b011: r = s;
      3'b100:         r = a & b;
      3'b101:         r = a | b;
      3'b110:         r = a ^ b;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  logic             sub_s;
  logic [WIDTH:0]   chain_s;   // chain_s[i] is the carry into slice i
  logic [WIDTH-1:0] res_s;
  logic [NIB-1:0]   nib_zero_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             negative_q, negative_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             carry_q, carry_d;
  logic [15:0]      dec_q, dec_d;

  assign sub_s      = (cntrl == 3'b011);
  assign chain_s[0] = sub_s;

  // The carry chain runs for every opcode, so C and V always reflect
  // A + (B ^ sub) + sub, even when the result mux selects a logic op.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic bb_s;
    logic sum_s;
    assign bb_s         = B[i] ^ sub_s;
    assign sum_s        = A[i] ^ bb_s ^ chain_s[i];
    assign chain_s[i+1] = (A[i] & bb_s) | (A[i] & chain_s[i]) | (bb_s & chain_s[i]);
    assign res_s[i]     = slice_mux(cntrl, A[i], B[i], sum_s);
  end

  // Zero detect reuses the decoder. With en tied high, a nibble is zero
  // exactly when only output 0 of its decode is set.
  for (genvar j = 0; j < NIB; j++) begin : g_zdet
    logic [15:0] nd_s;
    assign nd_s          = dec16(res_s[4*j +: 4], 1'b1);
    assign nib_zero_s[j] = nd_s[0] & ~|nd_s[15:1];
  end

  assign out_valid_d = in_valid;
  assign result_d    = res_s;
  assign negative_d  = res_s[WIDTH-1];
  assign zero_d      = &nib_zero_s;
  assign carry_d     = chain_s[WIDTH];
  assign overflow_d  = chain_s[WIDTH] ^ chain_s[WIDTH-1];
  assign dec_d       = dec16(dec_sel, dec_en);

  // Output register. Data loads every cycle whatever in_valid is;
  // reset clears every output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
      dec_q       <= 16'h0000;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      carry_q     <= carry_d;
      dec_q       <= dec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign negative  = negative_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign carry_out = carry_q;
  assign dec_out   = dec_q;

endmodule

// File: tb/tb_alu_slice_unit.sv
module tb_alu_slice_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  cntrl;
  logic [3:0]  dec_sel;
  logic        dec_en;
  logic        out_valid;
  logic [63:0] result;
  logic        negative;
  logic        zero;
  logic        overflow;
  logic        carry_out;
  logic [15:0] dec_out;

  typedef struct {
    logic [63:0] res;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
    logic [15:0] dec;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int pushed   = 0;
  int popped   = 0;

  alu_slice_unit #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .A(A), .B(B),
    .cntrl(cntrl), .dec_sel(dec_sel), .dec_en(dec_en),
    .out_valid(out_valid), .result(result), .negative(negative),
    .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .dec_out(dec_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operation and record its expected response.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                       input logic [3:0] sel, input logic en,
                       input logic [63:0] eres, input logic en_, input logic ez,
                       input logic ev, input logic ec, input logic [15:0] edec);
    exp_t e;
    A = a; B = b; cntrl = op; dec_sel = sel; dec_en = en; in_valid = 1'b1;
    e.res = eres; e.n = en_; e.z = ez; e.v = ev; e.c = ec; e.dec = edec;
    q.push_back(e);
    pushed++;
    @(negedge clk);
  endtask

  // Monitor: compare each valid output against the scoreboard head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got out_valid=1 expected no pending op");
      end else begin
        e = q.pop_front();
        popped++;
        chk("result",    result,             e.res);
        chk("negative",  64'(negative),      64'(e.n));
        chk("zero",      64'(zero),          64'(e.z));
        chk("overflow",  64'(overflow),      64'(e.v));
        chk("carry_out", 64'(carry_out),     64'(e.c));
        chk("dec_out",   64'(dec_out),       64'(e.dec));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish within 100000 time units");
    $fatal(1, "timeout");
  end

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PA   = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [63:0] PB   = 64'hFF00_FF00_FF00_FF00;

  initial begin
    // Hold reset with live-looking inputs; nothing may escape.
    reset = 1'b0; in_valid = 1'b1; A = ONES; B = ONES; cntrl = 3'b010;
    dec_sel = 4'd7; dec_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result",    result,         64'd0);
      chk("rst_flags",     64'({negative, zero, overflow, carry_out}), 64'd0);
      chk("rst_dec_out",   64'(dec_out),   64'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // First op after release: all-ones + all-ones = ...FE, carry out, no overflow.
    issue(ONES, ONES, 3'b010, 4'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0080);
    // Signed overflow on add.
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 4'd0, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    // 5 - 5.
    issue(64'd5, 64'd5, 3'b011, 4'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    // 0 - 1 borrows.
    issue(64'd0, 64'd1, 3'b011, 4'd0, 1'b0, ONES, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    // Wrap-around add.
    issue(ONES, 64'd1, 3'b010, 4'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    // Signed overflow on subtract.
    issue(64'h8000_0000_0000_0000, 64'd1, 3'b011, 4'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);

    // Idle cycle: outputs still load but out_valid must drop.
    in_valid = 1'b0;
    @(negedge clk);

    // Logic and pass ops. PA + PB carries out of bit 63 and bit 62, so C=1, V=0.
    issue(PA, PB, 3'b100, 4'd0, 1'b0, 64'hF000_F000_F000_F000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    issue(PA, PB, 3'b101, 4'd0, 1'b0, 64'hFFF0_FFF0_FFF0_FFF0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    issue(PA, PB, 3'b110, 4'd0, 1'b0, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    issue(PA, PB, 3'b000, 4'd0, 1'b0, PB,                      1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    issue(PA, PB, 3'b001, 4'd0, 1'b0, 64'd0,                   1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    issue(PA, PB, 3'b111, 4'd0, 1'b0, 64'd0,                   1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);

    // Decoder sweep with pass-B of zero, so result is 0 and Z is set.
    for (int k = 0; k < 16; k++) begin
      issue(64'd0, 64'd0, 3'b000, 4'(k), 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001 << k);
    end
    issue(64'd0, 64'd0, 3'b000, 4'd5, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Reset mid-stream drops the op presented with it.
    A = 64'd3; B = 64'd4; cntrl = 3'b010; dec_sel = 4'd2; dec_en = 1'b1; in_valid = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result",    result,         64'd0);
    chk("mid_rst_dec_out",   64'(dec_out),   64'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(64'd3, 64'd4, 3'b010, 4'd2, 1'b1, 64'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004);

    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    chk("responses_seen",     64'(popped),   64'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_slice_unit.md
Name: alu_slice_unit

Overview:
- Registered W-bit ripple-carry ALU built from 1-bit ALU slices, with a zero-detect and an auxiliary 4-to-16 one-hot decoder.
- Sits in the execute stage of the pipelined ARM datapath.
- Computes result and NZVC flags from A, B and a 3-bit opcode.
- All outputs are registered, giving one cycle of latency.

Parameters:
- WIDTH, 64, operand/result width in bits; legal values are multiples of 4 and at least 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset (low on a rising clk edge clears all state).
- in_valid  input  1  operands and opcode are valid this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cntrl  input  3  opcode.
- dec_sel  input  4  decoder select.
- dec_en  input  1  decoder enable.
- out_valid  output  1  registered copy of in_valid.
- result  output  WIDTH  registered ALU result.
- negative  output  1  registered N flag.
- zero  output  1  registered Z flag.
- overflow  output  1  registered V flag.
- carry_out  output  1  registered C flag.
- dec_out  output  16  registered one-hot decode.

Behaviour:
- Opcode map for cntrl:
  - 000: result = B (pass B).
  - 010: result = A + B.
  - 011: result = A - B.
  - 100: result = A & B.
  - 101: result = A | B.
  - 110: result = A ^ B.
  - 001 and 111: result = 0.
- Per-bit slice i:
  - Bb = B[i] ^ sub, where sub = (cntrl == 011).
  - sum = A[i] ^ Bb ^ cin.
  - cout = majority(A[i], Bb, cin).
  - The slice's result mux selects by cntrl.
- Carry chain:
  - cin of slice 0 = sub.
  - cin of slice i = cout of slice i-1.
  - The chain is always computed, for every opcode.
- Flags (combinational, then registered with result):
  - negative = result[WIDTH-1].
  - zero = 1 iff result == 0.
  - carry_out = cout[WIDTH-1].
  - overflow = cout[WIDTH-1] ^ cout[WIDTH-2].
- Flags for non-arithmetic opcodes:
  - carry_out and overflow are still driven from the adder chain of A + (B^sub) + sub.
  - Consumers use them only for 010/011.
- Subtract carry: carry_out = 1 means no borrow (A >= B unsigned).
- Zero-detect:
  - Built as a tree of the same 4-to-16 decoder function.
  - The requirement is functional only: exactly equivalent to a WIDTH-wide NOR of result.
- Decoder function:
  - out[k] = en & (sel == k), for k = 0..15.
  - Exactly one bit is high when en = 1; all bits are zero when en = 0.
  - The registered dec_out uses dec_sel and dec_en.
- Timing:
  - On every rising clk with reset high, all outputs load from the current inputs.
  - Latency is 1 cycle.
  - result, flags and dec_out load regardless of in_valid.
  - out_valid <= in_valid.
- Reset:
  - On a rising clk with reset low: result = 0, negative = 0, zero = 0, overflow = 0, carry_out = 0, dec_out = 0, out_valid = 0.
  - Reset overrides any simultaneous in_valid.
  - Reset mid-stream drops the in-flight result.
  - After reset deasserts, the first edge captures fresh inputs.
- Back-to-back: a new operation may be presented every cycle; there is no stall or backpressure.
- Wrap-around: add and sub are modulo 2^WIDTH.

Test Plan:
- Reset low for 2 clocks, with in_valid = 1 and A = B = all-ones -> all outputs 0 after each edge; release reset -> next edge shows the live result.
- cntrl = 010, A = 0x7FFF_FFFF_FFFF_FFFF, B = 1 -> result = 0x8000_0000_0000_0000, N = 1, Z = 0, V = 1, C = 0, one cycle after in_valid.
- cntrl = 011, A = 5, B = 5 -> result = 0, Z = 1, N = 0, C = 1, V = 0.
- cntrl = 011, A = 0, B = 1 -> result = all-ones, N = 1, C = 0, V = 0.
- cntrl = 010, A = all-ones, B = 1 -> result = 0, Z = 1, C = 1, V = 0.
- Logic and pass ops with A = 0xF0F0…, B = 0xFF00…:
  - 100 -> 0xF000…
  - 101 -> 0xFFF0…
  - 110 -> 0x0FF0…
  - 000 -> 0xFF00…
  - 001 and 111 -> 0 with Z = 1.
- Decoder: sweep dec_sel 0..15 with dec_en = 1 -> dec_out = 1 << dec_sel, one cycle later; dec_en = 0 -> dec_out = 0.
